// File: rtl/instr_mem_if.sv
// Fetch, response and program-load channels of the instruction memory.
// The master drives requests, loads and rsp_ready; the slave answers.
interface instr_mem_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19
);
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  req_addr;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [INSTR_W-1:0] rsp_data;
  logic [ADDR_W-1:0]  rsp_addr;
  logic               rsp_err;
  logic               ld_valid;
  logic               ld_ready;
  logic [ADDR_W-1:0]  ld_addr;
  logic [INSTR_W-1:0] ld_data;
  logic               busy;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_valid, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, ld_ready, busy
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_valid, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, ld_ready, busy
  );
endinterface

// File: rtl/instr_mem_pipelined.sv
// Generic FIFO: one-cycle push-to-pop, count output for credit accounting.
// Push into a full FIFO is ignored unless a pop frees the slot in the same cycle.
module instr_mem_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stor [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             full, push_eff, pop_eff;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign pop_dat  = stor[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_eff) stor[wr_ptr] <= push_dat;
  end

  // Explicit wrap keeps non-power-of-two depths correct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push_eff) - CW'(pop_eff);
    end
  end
endmodule

// Instruction memory with zeroing sweep after reset, LAT-cycle fetch pipe and
// credit-limited response FIFO; fetches are refused while the FIFO could overflow.
module instr_mem_pipelined #(
  parameter int INSTR_W   = 19,
  parameter int ADDR_W    = 12,
  parameter int DEPTH     = 4096,
  parameter int LAT       = 1,
  parameter int OUT_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  instr_mem_if.slave  bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(OUT_DEPTH + 1);

  typedef enum logic {CLEAR, RUN} state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [ADDR_W-1:0]  addr;
    logic               err;
  } rsp_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clr_ptr;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [CW-1:0]      inflight, fifo_count;
  logic               req_ready, ld_ready, busy;
  logic               req_fire, ld_fire, req_in_range, ld_in_range, ld_hit;
  logic               push, pop, fifo_empty;
  rsp_t               rd_ent, push_ent, pop_ent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CLEAR;
    else     state_q <= state_d;
  end

  // Credit is judged on registered counts only, so a pop frees a slot one cycle later.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    ld_ready  = 1'b0;
    req_ready = 1'b0;
    unique case (state_q)
      CLEAR: begin
        busy = 1'b1;
        if (clr_ptr == IDX_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        ld_ready  = 1'b1;
        req_ready = ({1'b0, inflight} + {1'b0, fifo_count}) < (CW + 1)'(OUT_DEPTH);
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      clr_ptr <= '0;
    else if (state_q == CLEAR && clr_ptr != IDX_W'(DEPTH - 1))
      clr_ptr <= clr_ptr + 1'b1;
  end

  assign req_in_range = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);
  assign ld_in_range  = {1'b0, bus.ld_addr}  < (ADDR_W + 1)'(DEPTH);
  assign req_fire     = bus.req_valid & req_ready;
  assign ld_fire      = bus.ld_valid & ld_ready;
  assign ld_hit       = ld_fire & ld_in_range & (bus.ld_addr == bus.req_addr);

  always_ff @(posedge clk) begin
    if (state_q == CLEAR)
      mem[clr_ptr] <= '0;
    else if (ld_fire && ld_in_range)
      mem[bus.ld_addr[IDX_W-1:0]] <= bus.ld_data;
  end

  // Write-first: a same-cycle load to the fetched word is forwarded.
  always_comb begin
    rd_ent      = '0;
    rd_ent.addr = bus.req_addr;
    rd_ent.err  = ~req_in_range;
    if (req_in_range)
      rd_ent.data = ld_hit ? bus.ld_data : mem[bus.req_addr[IDX_W-1:0]];
  end

  // The registered read itself is the first latency stage; LAT-1 more follow.
  if (LAT == 1) begin : g_nopipe
    assign push     = req_fire;
    assign push_ent = rd_ent;
  end else begin : g_pipe
    logic [LAT-2:0] p_vld;
    rsp_t           p_ent [LAT-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p_vld <= '0;
        for (int i = 0; i < LAT - 1; i++) p_ent[i] <= '0;
      end else begin
        p_vld[0] <= req_fire;
        p_ent[0] <= rd_ent;
        for (int i = 1; i < LAT - 1; i++) begin
          p_vld[i] <= p_vld[i-1];
          p_ent[i] <= p_ent[i-1];
        end
      end
    end

    assign push     = p_vld[LAT-2];
    assign push_ent = p_ent[LAT-2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= '0;
    else     inflight <= inflight + CW'(req_fire) - CW'(push);
  end

  instr_mem_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (OUT_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (pop_ent),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign pop           = bus.rsp_ready & ~fifo_empty;
  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_data  = fifo_empty ? '0 : pop_ent.data;
  assign bus.rsp_addr  = fifo_empty ? '0 : pop_ent.addr;
  assign bus.rsp_err   = fifo_empty ? 1'b0 : pop_ent.err;
  assign bus.req_ready = req_ready;
  assign bus.ld_ready  = ld_ready;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Scoreboard bench: accepted fetches queue their expected response from a word-array
// model; a negedge monitor checks readiness, timing and response contents.
module tb_instr_mem_pipelined;
  localparam int INSTR_W   = 19;
  localparam int ADDR_W    = 12;
  localparam int DEPTH     = 16;
  localparam int LAT       = 3;
  localparam int OUT_DEPTH = 4;

  typedef struct {
    logic [INSTR_W-1:0] data;
    logic [ADDR_W-1:0]  addr;
    logic               err;
    int                 e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   edges_rel = 0;
  int   earliest  = 0;
  exp_t q[$];
  logic [INSTR_W-1:0] model [DEPTH];

  instr_mem_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  instr_mem_pipelined #(
    .INSTR_W   (INSTR_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .LAT       (LAT),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    edges_rel <= rst ? 0 : edges_rel + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    int   vis;
    logic exp_busy;
    exp_t ent;
    if (rst) begin
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 0);
      chk("rst_rsp_addr", 32'(bus.rsp_addr), 0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 0);
      chk("rst_busy", 32'(bus.busy), 1);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_ld_ready", 32'(bus.ld_ready), 0);
      q.delete();
      earliest = 0;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else begin
      exp_busy = (edges_rel < DEPTH);
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("ld_ready", 32'(bus.ld_ready), 32'(!exp_busy));
      chk("req_ready", 32'(bus.req_ready), 32'(!exp_busy && q.size() < OUT_DEPTH));
      if (q.size() > 0) begin
        vis = (q[0].e + LAT - 1 > earliest) ? q[0].e + LAT - 1 : earliest;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(cyc >= vis));
        if (bus.rsp_valid) begin
          chk("rsp_data", 32'(bus.rsp_data), 32'(q[0].data));
          chk("rsp_addr", 32'(bus.rsp_addr), 32'(q[0].addr));
          chk("rsp_err", 32'(bus.rsp_err), 32'(q[0].err));
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            earliest = cyc + 1;
          end
        end
      end else begin
        chk("rsp_valid_idle", 32'(bus.rsp_valid), 0);
      end
      // Loads land before a same-cycle fetch reads the array.
      if (bus.ld_valid && bus.ld_ready && int'(bus.ld_addr) < DEPTH)
        model[int'(bus.ld_addr)] = bus.ld_data;
      if (bus.req_valid && bus.req_ready) begin
        ent.addr = bus.req_addr;
        ent.err  = (int'(bus.req_addr) >= DEPTH);
        ent.data = ent.err ? '0 : model[int'(bus.req_addr)];
        ent.e    = cyc + 1;
        q.push_back(ent);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bit dq, input int ra, input bit dl, input int la, input int ldat);
    bit pq = dq;
    bit pl = dl;
    bit aq, al;
    int guard = 0;
    bus.req_valid = dq;
    bus.req_addr  = ADDR_W'(ra);
    bus.ld_valid  = dl;
    bus.ld_addr   = ADDR_W'(la);
    bus.ld_data   = INSTR_W'(ldat);
    while ((pq || pl) && guard < 200) begin
      @(negedge clk);
      aq = bus.req_ready;
      al = bus.ld_ready;
      @(posedge clk);
      #1;
      if (pq && aq) begin pq = 0; bus.req_valid = 1'b0; end
      if (pl && al) begin pl = 0; bus.ld_valid = 1'b0; end
      guard++;
    end
    bus.req_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    chk("issue_accepted_in_time", 32'(guard < 200), 1);
  endtask

  task automatic drain();
    int guard = 0;
    bus.rsp_ready = 1'b1;
    while (q.size() > 0 && guard < 100) begin
      step(1);
      guard++;
    end
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    int acc, acc_edge, pop_edge, a;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b1;
    bus.ld_valid  = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    step(3);
    rst = 1'b0;
    step(DEPTH + 2);

    // Cleared memory reads zero everywhere.
    for (int i = 0; i < DEPTH; i++) issue(1, i, 0, 0, 0);
    drain();

    // Loads then back-to-back fetches, including an out-of-range address.
    issue(0, 0, 1, 10, 'h7000F);
    issue(0, 0, 1, 16, 'h198C0);
    issue(0, 0, 1, 6, 'h198C0);
    issue(1, 10, 0, 0, 0);
    issue(1, 16, 0, 0, 0);
    issue(1, 6, 0, 0, 0);
    drain();

    // Same-cycle load and fetch of one word.
    issue(1, 5, 1, 5, 'h1ABCD);
    drain();

    // Out-of-range fetch and load leave memory untouched.
    issue(0, 0, 1, 4, 'h0BEEF);
    issue(1, 20, 0, 0, 0);
    issue(0, 0, 1, 20, 'h55555);
    issue(1, 4, 0, 0, 0);
    drain();

    // Credit limit with the consumer stalled.
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = ADDR_W'(7);
    acc = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.req_ready) acc++;
      @(posedge clk);
      #1;
    end
    chk("credit_accepts", 32'(acc), 32'(OUT_DEPTH));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    pop_edge = cyc + 1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    acc = 0;
    acc_edge = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.req_ready) begin acc++; acc_edge = cyc + 1; end
      @(posedge clk);
      #1;
    end
    chk("credit_after_pop", 32'(acc), 1);
    chk("credit_after_pop_edge", 32'(acc_edge), 32'(pop_edge + 1));
    bus.req_valid = 1'b0;
    drain();

    // Randomized traffic with frequent address collisions.
    repeat (300) begin
      a = $urandom_range(0, 23);
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_addr  = ADDR_W'(a);
      bus.ld_valid  = ($urandom_range(0, 3) == 0);
      bus.ld_addr   = ($urandom_range(0, 3) == 0) ? ADDR_W'(a) : ADDR_W'($urandom_range(0, 23));
      bus.ld_data   = INSTR_W'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    bus.req_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    drain();

    // Reset with responses in flight wipes everything, including the program.
    issue(0, 0, 1, 3, 'h12345);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = ADDR_W'(3);
    step(3);
    bus.req_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("midrst_busy", 32'(bus.busy), 1);
    chk("midrst_req_ready", 32'(bus.req_ready), 0);
    step(2);
    rst = 1'b0;
    step(DEPTH + 2);
    issue(1, 3, 0, 0, 0);
    drain();
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
